int_sync_crossing_sink: RTL

Receive-side stage of the interrupt synchronous-crossing pair: takes the raw interrupt vector driven across the clock boundary by the source stage and re-times it into the local clock domain through a multi-flop synchronizer. It optionally removes glitches with a per-bit stability filter and latches edge-type interrupts into software-clearable pending bits. Its output feeds the local interrupt controller (PLIC/CLINT fan-in) as clean, single-domain levels.

---
 rtl/int_sync_pkg.sv | 10 +
 rtl/int_sync_sink_bit.sv | 41 ++++
 rtl/int_sync_crossing_sink.sv | 35 +++
 3 files changed

// File: rtl/int_sync_pkg.sv
// int_sync_pkg: shared limits and helpers for the interrupt crossing sink
package int_sync_pkg;
  localparam int MAX_INT = 64;
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 4;
  localparam int MAX_FILTER = 255;
  function automatic int cnt_width(input int f);
    return (f < 1) ? 1 : $clog2(f + 1);
  endfunction
endpackage

// File: rtl/int_sync_sink_bit.sv
// int_sync_sink_bit: one interrupt line's synchronizer, stability filter and edge latch
module int_sync_sink_bit
  import int_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_CYCLES = 0,
  parameter bit EDGE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  input  logic clr,
  output logic out,
  output logic raw
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES);
  logic [SYNC_STAGES-1:0] sh;
  logic sync, stable, stable_nxt, pending;
  logic [CW-1:0] cnt, cnt_nxt;
  assign sync = sh[SYNC_STAGES-1];
  // with FILTER_CYCLES = 0 cnt stays at CMAX, so every change is accepted at once
  always_comb begin
    stable_nxt = (sync != stable && cnt == CMAX) ? sync : stable;
    cnt_nxt = (sync == stable || cnt == CMAX) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sh <= '0;
      stable <= 1'b0;
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      sh <= {sh[SYNC_STAGES-2:0], d};
      stable <= stable_nxt;
      cnt <= cnt_nxt;
      pending <= EDGE && ((stable_nxt && !stable) || (pending && !clr));
    end
  assign out = EDGE ? pending : stable;
  assign raw = stable;
endmodule

// File: rtl/int_sync_crossing_sink.sv
// int_sync_crossing_sink: re-times a crossing interrupt vector into the local clock domain
module int_sync_crossing_sink
  import int_sync_pkg::*;
#(
  parameter int NUM_INT = 1,
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_CYCLES = 0,
  parameter logic [NUM_INT-1:0] EDGE_MASK = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in_sync,
  input  logic [NUM_INT-1:0] int_clr,
  output logic [NUM_INT-1:0] auto_out,
  output logic [NUM_INT-1:0] int_raw
);
  for (genvar i = 0; i < NUM_INT; i++) begin : g_bit
    int_sync_sink_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .EDGE(EDGE_MASK[i])
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .d(auto_in_sync[i]),
      .clr(int_clr[i]),
      .out(auto_out[i]),
      .raw(int_raw[i])
    );
  end
  a_params: assert property (@(posedge clock)
    NUM_INT >= 1 && NUM_INT <= MAX_INT &&
    SYNC_STAGES >= MIN_SYNC && SYNC_STAGES <= MAX_SYNC &&
    FILTER_CYCLES >= 0 && FILTER_CYCLES <= MAX_FILTER);
endmodule
